// File: rtl/fila_pkg.sv
// rtl/fila_pkg.sv - shared types and constants for the queue front-end controller
package fila_pkg;

    localparam int DATA_W        = 8;
    localparam int DEPTH_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE,
        ENQ,
        DEQ,
        CAPT,
        HOLD
    } fila_state_t;

endpackage

// File: rtl/botao_sync.sv
// rtl/botao_sync.sv - button synchronizer with optional debounce (FILA_CTRL_DEBOUNCE_EN)
module botao_sync
`ifdef FILA_CTRL_DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CYCLES = 16
)
`endif
(
    input  logic clk_10KHz,
    input  logic reset,
    input  logic button,
    output logic level,
    output logic rise
);

    logic [1:0] sync;
    logic       level_q;

    always_ff @(posedge clk_10KHz) begin
        if (!reset) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], button};
        end
    end

`ifdef FILA_CTRL_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] cnt;
    logic             filt;

    // cnt counts consecutive samples that disagree with the filtered level
    always_ff @(posedge clk_10KHz) begin
        if (!reset) begin
            cnt  <= '0;
            filt <= 1'b0;
        end else if (sync[1] == filt) begin
            cnt  <= '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            filt <= sync[1];
            cnt  <= '0;
        end else begin
            cnt  <= cnt + 1'b1;
        end
    end

    assign level = filt;
`else
    assign level = sync[1];
`endif

    always_ff @(posedge clk_10KHz) begin
        if (!reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/fila_ctrl.sv
// rtl/fila_ctrl.sv - push/pop button front-end for a queue; debounce via FILA_CTRL_DEBOUNCE_EN
module fila_ctrl
    import fila_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
`ifdef FILA_CTRL_DEBOUNCE_EN
    ,
    parameter int DEBOUNCE_CYCLES = 16
`endif
)
(
    input  logic              clk_10KHz,
    input  logic              reset,
    input  logic              push_in,
    input  logic              pop_in,
    input  logic [DATA_W-1:0] sw_in,
    input  logic [DATA_W-1:0] len_in,
    input  logic [DATA_W-1:0] fila_data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              enqueue_out,
    output logic              dequeue_out,
    output logic [DATA_W-1:0] value_out,
    output logic              valid_out,
    output logic              full_out,
    output logic              empty_out,
    output logic              error_out
);

    fila_state_t state, state_nxt;
    logic        push_lvl, push_rise;
    logic        pop_lvl, pop_rise;
    logic        load_data, capture, refuse;

`ifdef FILA_CTRL_DEBOUNCE_EN
    botao_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_push (
`else
    botao_sync u_push (
`endif
        .clk_10KHz (clk_10KHz),
        .reset     (reset),
        .button    (push_in),
        .level     (push_lvl),
        .rise      (push_rise)
    );

`ifdef FILA_CTRL_DEBOUNCE_EN
    botao_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pop (
`else
    botao_sync u_pop (
`endif
        .clk_10KHz (clk_10KHz),
        .reset     (reset),
        .button    (pop_in),
        .level     (pop_lvl),
        .rise      (pop_rise)
    );

    assign full_out  = (len_in >= DATA_W'(DEPTH));
    assign empty_out = (len_in == '0);

    always_comb begin
        state_nxt = state;
        load_data = 1'b0;
        capture   = 1'b0;
        refuse    = 1'b0;
        case (state)
            IDLE: begin
                if (push_rise && pop_rise) begin
                    refuse    = 1'b1;
                    state_nxt = HOLD;
                end else if (push_rise) begin
                    if (full_out) begin
                        refuse    = 1'b1;
                        state_nxt = HOLD;
                    end else begin
                        load_data = 1'b1;
                        state_nxt = ENQ;
                    end
                end else if (pop_rise) begin
                    if (empty_out) begin
                        refuse    = 1'b1;
                        state_nxt = HOLD;
                    end else begin
                        state_nxt = DEQ;
                    end
                end
            end
            ENQ:  state_nxt = HOLD;
            DEQ:  state_nxt = CAPT;
            CAPT: begin
                capture   = 1'b1;
                state_nxt = HOLD;
            end
            HOLD: begin
                // wait for both buttons released so a held button yields one request
                if (!push_lvl && !pop_lvl) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_10KHz) begin
        if (!reset) begin
            state     <= IDLE;
            data_out  <= '0;
            value_out <= '0;
            valid_out <= 1'b0;
            error_out <= 1'b0;
        end else begin
            state     <= state_nxt;
            valid_out <= capture;
            error_out <= refuse;
            if (load_data) begin
                data_out <= sw_in;
            end
            if (capture) begin
                value_out <= fila_data_in;
            end
        end
    end

    assign enqueue_out = (state == ENQ);
    assign dequeue_out = (state == DEQ);

endmodule
